// File: rtl/rr_channel_scheduler_if.sv
// Handshake bundle between a request source and the round-robin channel scheduler.
// The master drives requests and hold length; the slave returns the granted select.
interface rr_channel_scheduler_if #(
    parameter int N_CH   = 8,
    parameter int SEL_W  = 3,
    parameter int HOLD_W = 4
);
    logic [N_CH-1:0]   req;
    logic [HOLD_W-1:0] hold_len;
    logic              done;
    logic [SEL_W-1:0]  sel;
    logic              sel_valid;
    logic              grant_start;

    modport master (
        output req, hold_len, done,
        input  sel, sel_valid, grant_start
    );

    modport slave (
        input  req, hold_len, done,
        output sel, sel_valid, grant_start
    );
endinterface

// File: rtl/rr_channel_scheduler.sv
// Round-robin grant of one of 8 channels held for a programmable length, with a
// mandatory one-cycle gap between grants so the downstream one-hot decoder breaks before it makes.
module rr_channel_scheduler #(
    parameter int N_CH   = 8,
    parameter int SEL_W  = 3,
    parameter int HOLD_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    rr_channel_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

    state_t            state_reg;
    logic [SEL_W-1:0]  ptr_reg;
    logic [SEL_W-1:0]  sel_reg;
    logic              valid_reg;
    logic              start_reg;
    logic [HOLD_W-1:0] cnt_reg;

    logic [N_CH-1:0]   rot_req;
    logic [SEL_W-1:0]  off_next;
    logic [SEL_W-1:0]  winner_next;
    logic [HOLD_W-1:0] load_next;
    logic              any_req;

    // rot_req[gi] is the request of channel ptr+1+gi, so bit 0 has highest priority.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_rot
            assign rot_req[gi] = bus.req[ptr_reg + SEL_W'(gi + 1)];
        end
    endgenerate

    always_comb begin
        off_next = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot_req[i]) off_next = SEL_W'(i);
        end
        winner_next = ptr_reg + off_next + SEL_W'(1);
        any_req     = |bus.req;
        load_next   = (bus.hold_len == '0) ? HOLD_W'(1) : bus.hold_len;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            ptr_reg   <= SEL_W'(N_CH - 1);
            sel_reg   <= '0;
            valid_reg <= 1'b0;
            start_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE, GAP: begin
                    start_reg <= 1'b0;
                    valid_reg <= 1'b0;
                    state_reg <= IDLE;
                    if (any_req) begin
                        sel_reg   <= winner_next;
                        ptr_reg   <= winner_next;
                        cnt_reg   <= load_next;
                        valid_reg <= 1'b1;
                        start_reg <= 1'b1;
                        state_reg <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    start_reg <= 1'b0;
                    // cnt_reg holds the number of ACTIVE cycles left including this one.
                    if (cnt_reg == HOLD_W'(1) || bus.done) begin
                        valid_reg <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= GAP;
                    end else begin
                        cnt_reg <= cnt_reg - HOLD_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                    start_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel         = sel_reg;
    assign bus.sel_valid   = valid_reg;
    assign bus.grant_start = start_reg;
endmodule

// File: doc/rr_channel_scheduler.md
Name: rr_channel_scheduler

Overview:
- Round-robin scheduler that selects one of 8 requesting channels and holds the grant for a programmable number of cycles.
- Sits directly upstream of the 3-to-8 one-hot channel decoder:
  - `sel` drives the decoder's 3-bit select input.
  - `~sel_valid` drives the decoder's reset.
- Guarantees break-before-make: the one-hot output is all zeros for exactly one cycle between consecutive grants.

Parameters:
- N_CH, 8, number of channels; fixed at 8 to match the 3-bit select.
- SEL_W, 3, select width; equals log2(N_CH).
- HOLD_W, 4, width of the hold-length input.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset; synchronous, active-high
- req  input  8  per-channel request, level-sensitive; bit i = channel i
- hold_len  input  HOLD_W  grant duration in cycles; sampled at grant; 0 treated as 1
- done  input  1  early release of the current grant; honoured only in ACTIVE
- sel  output  SEL_W  index of the granted channel
- sel_valid  output  1  high while a grant is active
- grant_start  output  1  one-cycle pulse in the first ACTIVE cycle of each grant

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high) clears the following:
  - state=IDLE
  - sel=0, sel_valid=0, grant_start=0
  - hold counter=0
  - last-grant pointer=7, so the first search begins at channel 0.
- FSM states:
  - IDLE: no grant. If |req, arbitrate and go to ACTIVE; else stay.
  - ACTIVE:
    - sel_valid=1.
    - Counter decrements each cycle.
    - Leave when the counter reaches its last cycle or done=1.
    - Exit goes to GAP.
  - GAP:
    - Exactly one cycle with sel_valid=0.
    - Arbitrates like IDLE: if |req, go to ACTIVE; else go to IDLE.
- Arbitration:
  - Search order is ptr+1, ptr+2, … ptr+8, all mod 8; the first set req bit wins.
  - On a grant:
    - sel <= winner and ptr <= winner.
    - The counter loads max(hold_len,1).
  - A single requester is therefore re-granted after each GAP.
- Latency:
  - If req is sampled at edge k in IDLE or GAP, sel_valid=1 and grant_start=1 from cycle k+1.
  - sel_valid stays high for exactly L = max(hold_len,1) cycles unless released early by done.
- Back-to-back grants:
  - With continuous requests, the period is L+1 cycles.
  - sel_valid is low for exactly 1 cycle between grants.
- done:
  - done=1 in an ACTIVE cycle makes that cycle the last ACTIVE cycle.
  - done coinciding with counter expiry has the same effect.
  - done is ignored in IDLE and GAP.
- req changes during ACTIVE are ignored: the grant runs to completion even if its req drops.
- hold_len changes during ACTIVE are ignored.
- sel retains the last granted index while sel_valid=0. Only reset clears it.
- grant_start is high only in the first ACTIVE cycle.
- Reset asserted mid-ACTIVE:
  - Next cycle: sel_valid=0, sel=0, state IDLE, ptr=7.
  - Any in-flight grant is discarded.
- Reset has priority over every other input.

Test Plan:
1. Single requester:
   - Stimulus: release reset; req=8'b0000_0100, hold_len=3, held.
   - Response: sel=2 with sel_valid=1 for 3 cycles starting 1 cycle after req is sampled; grant_start on the first of them; sel_valid=0 for 1 cycle; then ch2 is re-granted for 3 cycles, repeating.
2. All channels requesting:
   - Stimulus: req=8'hFF, hold_len=1.
   - Response: sel sequence 0,1,2,3,4,5,6,7,0; each grant is 1 valid cycle followed by 1 gap cycle; grant_start is high on every valid cycle.
3. Fairness and wrap:
   - Stimulus: after a grant to ch0, req=8'b1000_0001, hold_len=2.
   - Response: grants go to ch7 then ch0 then ch7; a channel is never granted twice in a row while another is requesting.
4. Zero hold length:
   - Stimulus: hold_len=0, req=8'b0001_0000.
   - Response: sel=4 valid for exactly 1 cycle per grant, identical to hold_len=1.
5. Early release:
   - Stimulus: hold_len=5, req=8'b0000_0010, done=1 in the 2nd ACTIVE cycle.
   - Response: sel_valid high for 2 cycles only, then the GAP cycle; done pulsed during GAP or IDLE has no effect.
6. Reset mid-grant and ignored inputs:
   - Stimulus: reset asserted in the 3rd cycle of a hold_len=8 grant of ch5; then req=8'hFF.
   - Response: the cycle after reset shows sel=0, sel_valid=0; the first post-reset grant is ch0.
   - Also: dropping req or changing hold_len mid-grant does not shorten the grant.
